// File: rtl/axi_cdc_quiesce_ctrl.sv
package axi_cdc_quiesce_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ax_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic      aw_ready;
        logic      w_ready;
        b_chan_t   b;
        logic      b_valid;
        logic      ar_ready;
        r_chan_t   r;
        logic      r_valid;
    } axi_resp_t;

endpackage

// Gates AW/AR/W ahead of an AXI CDC, counts in-flight bursts and reports when the port is drained.
// Latency: 0 cycles on all channels; quiesce request acts 1 cycle later, quiesced_o 2 cycles after the last response.
// Backpressure: a gated channel drives valid=0 downstream and ready=0 upstream in the same cycle; B/R never stall here.
module axi_cdc_quiesce_ctrl #(
    parameter int unsigned MaxTxn     = 8,
    parameter type         axi_req_t  = axi_cdc_quiesce_pkg::axi_req_t,
    parameter type         axi_resp_t = axi_cdc_quiesce_pkg::axi_resp_t
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  axi_req_t                      slv_req_i,
    output axi_resp_t                     slv_resp_o,
    output axi_req_t                      mst_req_o,
    input  axi_resp_t                     mst_resp_i,
    input  logic                          quiesce_req_i,
    output logic                          quiesced_o,
    output logic [$clog2(MaxTxn+1)-1:0]   wr_outstanding_o,
    output logic [$clog2(MaxTxn+1)-1:0]   rd_outstanding_o
);

    localparam int unsigned CntW = $clog2(MaxTxn + 1);

    typedef logic [CntW-1:0]      cnt_t;
    typedef logic signed [CntW:0] open_t;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StIsolated
    } state_e;

    state_e state_q, state_d;
    cnt_t   wr_cnt_q, rd_cnt_q;
    open_t  w_open_q;

    logic wr_full, rd_full;
    logic w_open_pos, w_open_neg;
    logic aw_gate, ar_gate, w_gate;
    logic aw_hs, w_last_hs, b_hs, ar_hs, r_last_hs;

    assign wr_full    = (wr_cnt_q == cnt_t'(MaxTxn));
    assign rd_full    = (rd_cnt_q == cnt_t'(MaxTxn));
    assign w_open_neg = w_open_q[CntW];
    assign w_open_pos = !w_open_q[CntW] && (w_open_q != '0);

    always_comb begin
        state_d = state_q;
        aw_gate = wr_full;
        ar_gate = rd_full;
        case (state_q)
            StRun: begin
                if (quiesce_req_i) state_d = StDrain;
            end
            StDrain: begin
                ar_gate = 1'b1;
                // AW only to pair with W beats that already went downstream
                if (!w_open_neg) aw_gate = 1'b1;
                if (!quiesce_req_i) begin
                    state_d = StRun;
                end else if (wr_cnt_q == '0 && rd_cnt_q == '0 && w_open_q == '0) begin
                    state_d = StIsolated;
                end
            end
            StIsolated: begin
                aw_gate = 1'b1;
                ar_gate = 1'b1;
                if (!quiesce_req_i) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    assign aw_hs = slv_req_i.aw_valid & mst_resp_i.aw_ready & ~aw_gate;

    always_comb begin
        w_gate = 1'b0;
        case (state_q)
            StDrain:    w_gate = !w_open_pos && !aw_hs;
            StIsolated: w_gate = 1'b1;
            default:    w_gate = 1'b0;
        endcase
    end

    assign w_last_hs = slv_req_i.w_valid & mst_resp_i.w_ready & slv_req_i.w.last & ~w_gate;
    assign ar_hs     = slv_req_i.ar_valid & mst_resp_i.ar_ready & ~ar_gate;
    assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;
    assign r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;

    always_comb begin
        mst_req_o           = slv_req_i;
        mst_req_o.aw_valid  = slv_req_i.aw_valid & ~aw_gate;
        mst_req_o.w_valid   = slv_req_i.w_valid & ~w_gate;
        mst_req_o.ar_valid  = slv_req_i.ar_valid & ~ar_gate;
        slv_resp_o          = mst_resp_i;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & ~aw_gate;
        slv_resp_o.w_ready  = mst_resp_i.w_ready & ~w_gate;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ~ar_gate;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StRun;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            w_open_q <= '0;
        end else begin
            state_q <= state_d;
            case ({aw_hs, b_hs})
                2'b10:   wr_cnt_q <= wr_cnt_q + cnt_t'(1);
                2'b01:   wr_cnt_q <= wr_cnt_q - cnt_t'(1);
                default: wr_cnt_q <= wr_cnt_q;
            endcase
            case ({ar_hs, r_last_hs})
                2'b10:   rd_cnt_q <= rd_cnt_q + cnt_t'(1);
                2'b01:   rd_cnt_q <= rd_cnt_q - cnt_t'(1);
                default: rd_cnt_q <= rd_cnt_q;
            endcase
            // negative while W beats run ahead of their AW
            case ({aw_hs, w_last_hs})
                2'b10:   w_open_q <= w_open_q + open_t'(1);
                2'b01:   w_open_q <= w_open_q - open_t'(1);
                default: w_open_q <= w_open_q;
            endcase
        end
    end

    assign quiesced_o       = (state_q == StIsolated);
    assign wr_outstanding_o = wr_cnt_q;
    assign rd_outstanding_o = rd_cnt_q;

endmodule

// File: tb/tb_axi_cdc_quiesce_ctrl.sv
// Bench for axi_cdc_quiesce_ctrl: directed scenarios plus random traffic against an
// event-total model (outstanding = accepted - completed, mode 0/1/2 = run/drain/isolated).
module tb_axi_cdc_quiesce_ctrl;
    import axi_cdc_quiesce_pkg::*;

    localparam int MAXT = 4;
    localparam int CW   = $clog2(MAXT + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          quiesce;
    axi_req_t      slv_req, mst_req;
    axi_resp_t     slv_resp, mst_resp;
    logic          quiesced;
    logic [CW-1:0] wr_out, rd_out;

    axi_cdc_quiesce_ctrl #(.MaxTxn(MAXT)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .slv_req_i        (slv_req),
        .slv_resp_o       (slv_resp),
        .mst_req_o        (mst_req),
        .mst_resp_i       (mst_resp),
        .quiesce_req_i    (quiesce),
        .quiesced_o       (quiesced),
        .wr_outstanding_o (wr_out),
        .rd_outstanding_o (rd_out)
    );

    int vectors     = 0;
    int miscompares = 0;

    // model: cumulative event totals since the last reset
    int aw_tot, b_tot, wl_tot, ar_tot, rl_tot;
    int mode;
    bit model_live = 1'b0;
    int rd_beats[$];

    int m_wr, m_rd, m_wo;
    bit m_awh, m_wlh, m_bh, m_arh, m_rlh, m_rh;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        slv_req             = '0;
        mst_resp            = '0;
        slv_req.b_ready     = 1'b1;
        slv_req.r_ready     = 1'b1;
        mst_resp.aw_ready   = 1'b1;
        mst_resp.w_ready    = 1'b1;
        mst_resp.ar_ready   = 1'b1;
    endtask

    // Let inputs settle, then check every output against the model.
    task automatic settle();
        bit aw_ok, ar_ok, w_ok, viol;
        axi_req_t  er;
        axi_resp_t ep;
        #1;
        m_wr  = aw_tot - b_tot;
        m_rd  = ar_tot - rl_tot;
        m_wo  = aw_tot - wl_tot;
        aw_ok = (m_wr < MAXT) && (mode == 0 || (mode == 1 && m_wo < 0));
        ar_ok = (m_rd < MAXT) && (mode == 0);
        m_awh = slv_req.aw_valid && mst_resp.aw_ready && aw_ok;
        w_ok  = (mode == 0) || (mode == 1 && (m_wo > 0 || m_awh));
        m_wlh = slv_req.w_valid && mst_resp.w_ready && w_ok && slv_req.w.last;
        m_arh = slv_req.ar_valid && mst_resp.ar_ready && ar_ok;
        m_bh  = mst_resp.b_valid && slv_req.b_ready;
        m_rh  = mst_resp.r_valid && slv_req.r_ready;
        m_rlh = m_rh && mst_resp.r.last;
        if (model_live) begin
            er          = slv_req;
            er.aw_valid = slv_req.aw_valid && aw_ok;
            er.w_valid  = slv_req.w_valid && w_ok;
            er.ar_valid = slv_req.ar_valid && ar_ok;
            ep          = mst_resp;
            ep.aw_ready = mst_resp.aw_ready && aw_ok;
            ep.w_ready  = mst_resp.w_ready && w_ok;
            ep.ar_ready = mst_resp.ar_ready && ar_ok;
            chk("mst_req", 256'(mst_req), 256'(er));
            chk("slv_resp", 256'(slv_resp), 256'(ep));
            chk("wr_outstanding", 256'(wr_out), 256'(m_wr));
            chk("rd_outstanding", 256'(rd_out), 256'(m_rd));
            chk("quiesced", 256'(quiesced), 256'(mode == 2));
            viol = (m_bh && !m_awh && m_wr == 0) || (m_rlh && !m_arh && m_rd == 0);
            chk("counter_underflow", 256'(viol), 256'(0));
        end
    endtask

    // Apply the clock edge to the model, then move to just after the edge.
    task automatic advance();
        if (rst) begin
            aw_tot = 0; b_tot = 0; wl_tot = 0; ar_tot = 0; rl_tot = 0;
            mode = 0;
            model_live = 1'b1;
            rd_beats.delete();
        end else if (model_live) begin
            case (mode)
                0: if (quiesce) mode = 1;
                1: if (!quiesce) mode = 0;
                   else if (m_wr == 0 && m_rd == 0 && m_wo == 0) mode = 2;
                default: if (!quiesce) mode = 0;
            endcase
            aw_tot += int'(m_awh);
            b_tot  += int'(m_bh);
            wl_tot += int'(m_wlh);
            ar_tot += int'(m_arh);
            rl_tot += int'(m_rlh);
            if (m_rh && rd_beats.size() > 0) begin
                if (rd_beats[0] <= 1) void'(rd_beats.pop_front());
                else rd_beats[0] = rd_beats[0] - 1;
            end
            if (m_arh) rd_beats.push_back(int'(slv_req.ar.len) + 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    initial begin
        rst = 1'b1;
        quiesce = 1'b0;
        idle();
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;

        // reset state
        chk("rst_quiesced", 256'(quiesced), 256'(0));
        chk("rst_wr", 256'(wr_out), 256'(0));
        chk("rst_rd", 256'(rd_out), 256'(0));

        // 4-beat write + 1-beat read, quiesce one cycle after AW
        idle(); slv_req.aw_valid = 1; slv_req.aw.len = 8'd3; slv_req.w_valid = 1;
        slv_req.ar_valid = 1; step();
        idle(); quiesce = 1; slv_req.w_valid = 1; step();
        idle(); slv_req.w_valid = 1; slv_req.ar_valid = 1; settle();
        chk("s1_ar_held", 256'(slv_resp.ar_ready), 256'(0));
        chk("s1_w_pass", 256'(mst_req.w_valid), 256'(1));
        advance();
        idle(); slv_req.w_valid = 1; slv_req.w.last = 1; slv_req.ar_valid = 1; settle();
        chk("s1_wlast_pass", 256'(mst_req.w_valid), 256'(1));
        advance();
        idle(); slv_req.ar_valid = 1; mst_resp.b_valid = 1; mst_resp.r_valid = 1;
        mst_resp.r.last = 1; step();
        idle(); slv_req.ar_valid = 1; settle();
        chk("s1_wr_zero", 256'(wr_out), 256'(0));
        chk("s1_rd_zero", 256'(rd_out), 256'(0));
        chk("s1_not_yet", 256'(quiesced), 256'(0));
        advance();
        idle(); settle();
        chk("s1_quiesced", 256'(quiesced), 256'(1));
        advance();
        quiesce = 0; step(); step();
        chk("s1_released", 256'(quiesced), 256'(0));

        // W ahead of its AW, then drain
        idle(); slv_req.w_valid = 1; slv_req.w.last = 1; step();
        idle(); quiesce = 1; step();
        idle(); slv_req.aw_valid = 1; settle();
        chk("s2_aw_accept", 256'(slv_resp.aw_ready), 256'(1));
        advance();
        idle(); mst_resp.b_valid = 1; settle();
        chk("s2_wr_one", 256'(wr_out), 256'(1));
        advance();
        idle(); step();
        settle();
        chk("s2_quiesced", 256'(quiesced), 256'(1));
        advance();
        quiesce = 0; step(); step();

        // outstanding-read limit
        for (int i = 0; i < MAXT; i++) begin
            idle(); slv_req.ar_valid = 1; step();
        end
        idle(); slv_req.ar_valid = 1; settle();
        chk("s3_ar_full", 256'(slv_resp.ar_ready), 256'(0));
        chk("s3_rd_max", 256'(rd_out), 256'(MAXT));
        advance();
        idle(); slv_req.ar_valid = 1; mst_resp.r_valid = 1; mst_resp.r.last = 1; settle();
        chk("s3_ar_still_full", 256'(slv_resp.ar_ready), 256'(0));
        advance();
        idle(); slv_req.ar_valid = 1; settle();
        chk("s3_ar_reopen", 256'(slv_resp.ar_ready), 256'(1));
        advance();
        for (int i = 0; i < MAXT; i++) begin
            idle(); mst_resp.r_valid = 1; mst_resp.r.last = 1; step();
        end

        // simultaneous increment and decrement
        idle(); slv_req.aw_valid = 1; step();
        idle(); slv_req.aw_valid = 1; mst_resp.b_valid = 1; slv_req.ar_valid = 1;
        mst_resp.r_valid = 1; mst_resp.r.last = 1; step();
        idle(); settle();
        chk("s4_wr_same", 256'(wr_out), 256'(1));
        chk("s4_rd_same", 256'(rd_out), 256'(0));
        advance();
        idle(); slv_req.w_valid = 1; slv_req.w.last = 1; step();
        idle(); slv_req.w_valid = 1; slv_req.w.last = 1; mst_resp.b_valid = 1; step();

        // release during drain with three writes open
        for (int i = 0; i < 3; i++) begin
            idle(); slv_req.aw_valid = 1; step();
        end
        idle(); quiesce = 1; step();
        idle(); quiesce = 0; slv_req.aw_valid = 1; settle();
        chk("s5_drain_gate", 256'(slv_resp.aw_ready), 256'(0));
        chk("s5_wr_three", 256'(wr_out), 256'(3));
        advance();
        idle(); slv_req.aw_valid = 1; settle();
        chk("s5_run_accept", 256'(slv_resp.aw_ready), 256'(1));
        chk("s5_quiesced", 256'(quiesced), 256'(0));
        advance();
        for (int i = 0; i < 4; i++) begin
            idle(); slv_req.w_valid = 1; slv_req.w.last = 1; mst_resp.b_valid = 1; step();
        end

        // reset while draining
        for (int i = 0; i < 2; i++) begin
            idle(); slv_req.aw_valid = 1; step();
        end
        idle(); quiesce = 1; step();
        idle(); rst = 1; step();
        rst = 0;
        idle(); slv_req.aw_valid = 1; settle();
        chk("s6_wr_clear", 256'(wr_out), 256'(0));
        chk("s6_rd_clear", 256'(rd_out), 256'(0));
        chk("s6_quiesced", 256'(quiesced), 256'(0));
        chk("s6_run_aw", 256'(mst_req.aw_valid), 256'(1));
        advance();
        idle(); quiesce = 0; slv_req.w_valid = 1; slv_req.w.last = 1; mst_resp.b_valid = 1;
        step();

        // random traffic
        rd_beats.delete();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) quiesce = ~quiesce;
            rst = ($urandom_range(0, 599) == 0);
            slv_req.aw.id      = 4'($urandom);
            slv_req.aw.addr    = $urandom;
            slv_req.aw.len     = 8'($urandom_range(0, 15));
            slv_req.aw_valid   = 1'($urandom_range(0, 1));
            slv_req.w.data     = $urandom;
            slv_req.w.strb     = 4'($urandom);
            slv_req.w.last     = ($urandom_range(0, 2) == 0) && (aw_tot - wl_tot > -MAXT);
            slv_req.w_valid    = 1'($urandom_range(0, 1));
            slv_req.b_ready    = ($urandom_range(0, 3) != 0);
            slv_req.ar.id      = 4'($urandom);
            slv_req.ar.addr    = $urandom;
            slv_req.ar.len     = 8'($urandom_range(0, 3));
            slv_req.ar_valid   = 1'($urandom_range(0, 1));
            slv_req.r_ready    = ($urandom_range(0, 3) != 0);
            mst_resp.aw_ready  = ($urandom_range(0, 3) != 0);
            mst_resp.w_ready   = ($urandom_range(0, 3) != 0);
            mst_resp.ar_ready  = ($urandom_range(0, 3) != 0);
            mst_resp.b.id      = 4'($urandom);
            mst_resp.b.resp    = 2'($urandom);
            mst_resp.b_valid   = (b_tot < aw_tot) && (b_tot < wl_tot) && ($urandom_range(0, 1) == 1);
            mst_resp.r.id      = 4'($urandom);
            mst_resp.r.data    = $urandom;
            mst_resp.r.resp    = 2'($urandom);
            mst_resp.r_valid   = (rd_beats.size() > 0) && ($urandom_range(0, 1) == 1);
            mst_resp.r.last    = (rd_beats.size() > 0) && (rd_beats[0] == 1);
            step();
        end
        rst = 0;
        quiesce = 0;
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
